// File: rtl/regfile_scoreboard.sv
// Three-read/one-write register file with a per-register busy scoreboard.
// The hazard unit stalls on busyN; BYPASS forwards same-cycle writes to the read ports.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] readRegExtra,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] readDataExtra,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserveReg,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic              busyExtra,
  output logic              anyBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  next_busy;
  logic              write_en;
  logic              reserve_en;

  assign write_en   = regWrite && !((ZERO_REG != 0) && (writeReg == '0));
  assign reserve_en = reserve && !((ZERO_REG != 0) && (reserveReg == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[writeReg] <= writeData;
    end
  end

  // Reserve is applied after the write-clear so a new producer wins over a retiring one.
  always_comb begin
    next_busy = busy;
    if (flush) begin
      next_busy = '0;
    end else begin
      if (write_en)   next_busy[writeReg]   = 1'b0;
      if (reserve_en) next_busy[reserveReg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= next_busy;
  end

  // Reset also masks the bypass path so every read port shows zero while reset is held.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              rst_now,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] value;
    value = stored;
    if ((BYPASS != 0) && wr_en && (wr_addr == addr)) value = wr_data;
    if (rst_now || ((ZERO_REG != 0) && (addr == '0))) value = '0;
    return value;
  endfunction

  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  logic [DATA_W-1:0] stored_extra;

  assign stored1      = regs[readReg1];
  assign stored2      = regs[readReg2];
  assign stored_extra = regs[readRegExtra];

  assign readData1     = read_mux(readReg1, stored1, reset, regWrite, writeReg, writeData);
  assign readData2     = read_mux(readReg2, stored2, reset, regWrite, writeReg, writeData);
  assign readDataExtra = read_mux(readRegExtra, stored_extra, reset, regWrite, writeReg, writeData);

  assign busy1     = busy[readReg1];
  assign busy2     = busy[readReg2];
  assign busyExtra = busy[readRegExtra];
  assign anyBusy   = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed plan steps plus random traffic against an array model,
// covering BYPASS=1, BYPASS=0 and a narrow 16x8 configuration.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1, readReg2, readRegExtra;
  logic        reserve;
  logic [4:0]  reserveReg;
  logic        flush;

  logic [31:0] rd1_b, rd2_b, rdx_b;
  logic        busy1_b, busy2_b, busyx_b, any_b;
  logic [31:0] rd1_n, rd2_n, rdx_n;
  logic        busy1_n, busy2_n, busyx_n, any_n;

  logic        s_regWrite;
  logic [2:0]  s_writeReg;
  logic [15:0] s_writeData;
  logic [2:0]  s_readReg1, s_readReg2, s_readRegExtra;
  logic        s_reserve;
  logic [2:0]  s_reserveReg;
  logic        s_flush;
  logic [15:0] s_rd1, s_rd2, s_rdx;
  logic        s_busy1, s_busy2, s_busyx, s_any;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .readRegExtra(readRegExtra),
    .readData1(rd1_b), .readData2(rd2_b), .readDataExtra(rdx_b),
    .reserve(reserve), .reserveReg(reserveReg), .flush(flush),
    .busy1(busy1_b), .busy2(busy2_b), .busyExtra(busyx_b), .anyBusy(any_b)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .readRegExtra(readRegExtra),
    .readData1(rd1_n), .readData2(rd2_n), .readDataExtra(rdx_n),
    .reserve(reserve), .reserveReg(reserveReg), .flush(flush),
    .busy1(busy1_n), .busy2(busy2_n), .busyExtra(busyx_n), .anyBusy(any_n)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_small (
    .clk(clk), .reset(reset), .regWrite(s_regWrite), .writeReg(s_writeReg), .writeData(s_writeData),
    .readReg1(s_readReg1), .readReg2(s_readReg2), .readRegExtra(s_readRegExtra),
    .readData1(s_rd1), .readData2(s_rd2), .readDataExtra(s_rdx),
    .reserve(s_reserve), .reserveReg(s_reserveReg), .flush(s_flush),
    .busy1(s_busy1), .busy2(s_busy2), .busyExtra(s_busyx), .anyBusy(s_any)
  );

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
    if (reset || a == 5'd0) return 32'h0;
    if (byp && regWrite && writeReg == a) return writeData;
    return m_regs[a];
  endfunction

  function automatic bit expAny();
    bit any_set = 1'b0;
    for (int i = 0; i < 32; i++) any_set |= m_busy[i];
    return any_set;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Storage and scoreboard update at a rising edge; reserve is applied last so it supersedes a write-clear.
  task automatic modelUpdate();
    if (reset) begin
      modelReset();
    end else begin
      if (regWrite && writeReg != 5'd0) m_regs[writeReg] = writeData;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (regWrite && writeReg != 5'd0) m_busy[writeReg] = 1'b0;
        if (reserve && reserveReg != 5'd0) m_busy[reserveReg] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("byp.readData1", rd1_b, expRead(readReg1, 1'b1));
    checkVal("byp.readData2", rd2_b, expRead(readReg2, 1'b1));
    checkVal("byp.readDataExtra", rdx_b, expRead(readRegExtra, 1'b1));
    checkVal("byp.busy1", {31'b0, busy1_b}, {31'b0, m_busy[readReg1]});
    checkVal("byp.busy2", {31'b0, busy2_b}, {31'b0, m_busy[readReg2]});
    checkVal("byp.busyExtra", {31'b0, busyx_b}, {31'b0, m_busy[readRegExtra]});
    checkVal("byp.anyBusy", {31'b0, any_b}, {31'b0, expAny()});
    checkVal("nob.readData1", rd1_n, expRead(readReg1, 1'b0));
    checkVal("nob.readData2", rd2_n, expRead(readReg2, 1'b0));
    checkVal("nob.readDataExtra", rdx_n, expRead(readRegExtra, 1'b0));
    checkVal("nob.busy1", {31'b0, busy1_n}, {31'b0, m_busy[readReg1]});
    checkVal("nob.busy2", {31'b0, busy2_n}, {31'b0, m_busy[readReg2]});
    checkVal("nob.busyExtra", {31'b0, busyx_n}, {31'b0, m_busy[readRegExtra]});
    checkVal("nob.anyBusy", {31'b0, any_n}, {31'b0, expAny()});
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                               input logic rsv, input logic [4:0] rr, input logic fl);
    regWrite   = we;
    writeReg   = wr;
    writeData  = wd;
    reserve    = rsv;
    reserveReg = rr;
    flush      = fl;
  endtask

  task automatic setReads(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rx);
    readReg1     = r1;
    readReg2     = r2;
    readRegExtra = rx;
  endtask

  // Check the pre-edge view, take the edge, advance the model, and land on the next falling edge.
  task automatic tick();
    #1 checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    setReads(5'd0, 5'd0, 5'd0);
    s_regWrite = 1'b0; s_writeReg = 3'd0; s_writeData = 16'h0;
    s_readReg1 = 3'd0; s_readReg2 = 3'd0; s_readRegExtra = 3'd0;
    s_reserve = 1'b0; s_reserveReg = 3'd0; s_flush = 1'b0;
    modelReset();
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Reset clears data and busy immediately, and swallows a write presented while held.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6, 1'b0);
    setReads(5'd5, 5'd6, 5'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    #1 checkOutput();
    reset = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6, 1'b0);
    modelReset();
    #1 checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();

    // Write-first bypass versus registered visibility.
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0);
    setReads(5'd7, 5'd7, 5'd5);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();

    // Zero register ignores writes and reserves.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
    setReads(5'd0, 5'd0, 5'd7);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();

    // Scoreboard lifecycle on r9.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    setReads(5'd1, 5'd9, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();

    // Same-cycle reserve and write, then reserve against flush.
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 1'b0);
    setReads(5'd3, 5'd4, 5'd9);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick();

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 11)), $urandom(),
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 11)), $urandom_range(0, 15) == 0);
      setReads(5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 31)));
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

    // Narrow configuration: fill every entry, then read back on all ports.
    for (int a = 0; a < 8; a++) begin
      s_regWrite  = 1'b1;
      s_writeReg  = 3'(a);
      s_writeData = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
    end
    s_regWrite = 1'b0;
    for (int a = 0; a < 8; a++) begin
      s_readReg1     = 3'(a);
      s_readReg2     = 3'(a + 1);
      s_readRegExtra = 3'(a + 3);
      #1;
      checkVal("small.readData1", {16'b0, s_rd1}, (s_readReg1 == 3'd0) ? 32'h0 : 32'hBEEF);
      checkVal("small.readData2", {16'b0, s_rd2}, (s_readReg2 == 3'd0) ? 32'h0 : 32'hBEEF);
      checkVal("small.readDataExtra", {16'b0, s_rdx}, (s_readRegExtra == 3'd0) ? 32'h0 : 32'hBEEF);
      checkVal("small.busy1", {31'b0, s_busy1}, 32'h0);
      checkVal("small.anyBusy", {31'b0, s_any}, 32'h0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
